// File: rtl/imm_extend_pkg.sv
// Shared constants for the immediate-extend stage: format-select encodings
// and the default output width.
package imm_extend_pkg;

  localparam int XLEN_DEFAULT = 32;

  // imm_src encodings. Values outside this set are reported through imm_err.
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;

endpackage

// File: rtl/imm_extend_stage_imm_decode.sv
// Combinational immediate decoder. It reassembles the RISC-V I/S/B/J
// immediates from instruction bits [31:7] and sign-extends them using the
// instruction MSB. U-type decoding exists only when IMM_EXTEND_UTYPE_EN is
// defined. Otherwise imm_src=4 is reported as unsupported.
module imm_decode
  import imm_extend_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SRCW = 3
) (
  input  logic [SRCW-1:0] imm_src,
  input  logic [24:0]     inp,
  output logic [XLEN-1:0] imm,
  output logic            imm_err
);

  // Every format is built at 64 bits and then truncated to XLEN. This avoids
  // zero-width replications when XLEN is 32.
  logic [63:0] wide;

  // Select the format and sign-extend it. Unsupported codes give zero and set the error flag.
  always_comb begin
    wide    = '0;
    imm_err = 1'b0;
    case (imm_src)
      SRCW'(IMM_I): wide = {{52{inp[24]}}, inp[24:13]};
      SRCW'(IMM_S): wide = {{52{inp[24]}}, inp[24:18], inp[4:0]};
      SRCW'(IMM_B): wide = {{51{inp[24]}}, inp[24], inp[0], inp[23:18], inp[4:1], 1'b0};
      SRCW'(IMM_J): wide = {{43{inp[24]}}, inp[24], inp[12:5], inp[13], inp[23:14], 1'b0};
`ifdef IMM_EXTEND_UTYPE_EN
      SRCW'(IMM_U): wide = {{32{inp[24]}}, inp[24:5], 12'b0};
`endif
      default: begin
        wide    = '0;
        imm_err = 1'b1;
      end
    endcase
  end

  assign imm = wide[XLEN-1:0];

endmodule

// File: rtl/imm_extend_stage.sv
// Immediate-extend pipeline stage with a 2-entry skid buffer.
// Optional feature macro: IMM_EXTEND_UTYPE_EN (enables U-type decode on imm_src=4).
//
// Handshake: an entry is accepted on a cycle where in_valid && in_ready. It
// leaves on a cycle where out_valid && out_ready. in_ready is registered and
// always equals !skid_valid. An entry in main stays put while it is not
// being taken, so imm and imm_err hold their values under backpressure.
// Asserting flush empties both slots at the next edge and drops any entry
// offered on the same cycle.
module imm_extend_stage
  import imm_extend_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int SRCW = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SRCW-1:0] imm_src,
  input  logic [24:0]     inp,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic            imm_err
);

  logic [XLEN-1:0] dec_imm;
  logic            dec_err;

  logic            main_valid;
  logic [XLEN-1:0] main_imm;
  logic            main_err;
  logic            skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic            skid_err;
  logic            in_ready_q;
  logic            accept;

  imm_decode #(
    .XLEN(XLEN),
    .SRCW(SRCW)
  ) u_decode (
    .imm_src(imm_src),
    .inp    (inp),
    .imm    (dec_imm),
    .imm_err(dec_err)
  );

  assign accept = in_valid & in_ready_q;

  // Skid-buffer state. Main refills from skid first to keep entries in order.
  // The skid slot fills only while main is stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_valid <= 1'b0;
      main_imm   <= '0;
      main_err   <= 1'b0;
      skid_valid <= 1'b0;
      skid_imm   <= '0;
      skid_err   <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      in_ready_q <= 1'b1;
    end else if (!main_valid || out_ready) begin
      // Main is empty or being taken this cycle.
      if (skid_valid) begin
        main_imm   <= skid_imm;
        main_err   <= skid_err;
        main_valid <= 1'b1;
        skid_valid <= 1'b0;
        in_ready_q <= 1'b1;
      end else if (accept) begin
        main_imm   <= dec_imm;
        main_err   <= dec_err;
        main_valid <= 1'b1;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (accept) begin
      // Main is stalled, so the new entry goes into skid.
      skid_imm   <= dec_imm;
      skid_err   <= dec_err;
      skid_valid <= 1'b1;
      in_ready_q <= 1'b0;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign imm       = main_imm;
  assign imm_err   = main_err;

endmodule

// File: tb/tb_imm_extend_stage.sv
// Bench for imm_extend_stage. It applies a table of single-entry decode
// vectors and then runs hand-written sequences for backpressure, flush and
// asynchronous reset. Output transfers are checked against an expected queue.
module tb_imm_extend_stage;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      imm_src;
  logic [24:0]     inp;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm;
  logic            imm_err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    string       name;
    logic [2:0]  src;
    logic [24:0] inp;
    logic [63:0] exp_imm;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  imm_extend_stage #(
    .XLEN(XLEN),
    .SRCW(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .imm_src  (imm_src),
    .inp      (inp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .imm      (imm),
    .imm_err  (imm_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] src, input logic [24:0] d);
    in_valid = v;
    imm_src  = src;
    inp      = d;
  endtask

  // Scoreboard. A transfer is visible on the falling edge before the rising edge that completes it.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected: got %h expected no transfer", imm);
      end else begin
        logic [XLEN-1:0] e;
        e = exp_q.pop_front();
        if (imm !== e) $display("FAIL sb_order: got %h expected %h", imm, e);
        else pass_cnt++;
      end
    end
  end

  initial begin
    vecs[0]  = '{"i_neg1",   3'd0, 25'h1FFE001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[1]  = '{"i_pos",    3'd0, 25'h0FFE000, 64'h0000_0000_0000_07FF, 1'b0};
    vecs[2]  = '{"s_pos",    3'd1, 25'h0040005, 64'h0000_0000_0000_0025, 1'b0};
    vecs[3]  = '{"s_neg",    3'd1, 25'h1FC001F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[4]  = '{"b_neg4",   3'd2, 25'h1FC001D, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
    vecs[5]  = '{"b_bit11",  3'd2, 25'h0000001, 64'h0000_0000_0000_0800, 1'b0};
    vecs[6]  = '{"j_8",      3'd3, 25'h0010000, 64'h0000_0000_0000_0008, 1'b0};
    vecs[7]  = '{"j_mid",    3'd3, 25'h0002020, 64'h0000_0000_0000_1800, 1'b0};
    vecs[8]  = '{"j_neg",    3'd3, 25'h1000000, 64'hFFFF_FFFF_FFF0_0000, 1'b0};
    vecs[9]  = '{"src7",     3'd7, 25'h1FFE001, 64'h0,                   1'b1};
    vecs[10] = '{"src5",     3'd5, 25'h1FFFFFF, 64'h0,                   1'b1};
    vecs[11] = '{"src6",     3'd6, 25'h0123456, 64'h0,                   1'b1};
`ifdef IMM_EXTEND_UTYPE_EN
    vecs[12] = '{"u_type",   3'd4, 25'h1000000, 64'hFFFF_FFFF_8000_0000, 1'b0};
`else
    vecs[12] = '{"src4_off", 3'd4, 25'h1000000, 64'h0,                   1'b1};
`endif

    // Reset state, checked between edges.
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 3'd0, 25'h0);
    #2;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_imm",       64'(imm),       64'd0);
    chk("rst_imm_err",   64'(imm_err),   64'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // Table vectors are offered back to back with out_ready high.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].src, vecs[i].inp);
      exp_q.push_back(vecs[i].exp_imm[XLEN-1:0]);
      step();
      drive(1'b0, 3'd0, 25'h0);
      chk({vecs[i].name, "_valid"}, 64'(out_valid), 64'd1);
      chk({vecs[i].name, "_imm"},   64'(imm),       64'(vecs[i].exp_imm[XLEN-1:0]));
      chk({vecs[i].name, "_err"},   64'(imm_err),   64'(vecs[i].exp_err));
    end
    step();
    chk("vec_drained", 64'(out_valid), 64'd0);

    // Backpressure: three entries back to back while out_ready is low.
    out_ready = 1'b0;
    exp_q.push_back(XLEN'(1));
    exp_q.push_back(XLEN'(2));
    exp_q.push_back(XLEN'(3));
    drive(1'b1, 3'd0, 25'h0002000);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_imm",   64'(imm),       64'd1);
    chk("bp_ready1",  64'(in_ready),  64'd1);
    drive(1'b1, 3'd0, 25'h0004000);
    step();
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    chk("bp_a_hold",     64'(imm),      64'd1);
    drive(1'b1, 3'd0, 25'h0006000);
    step();
    chk("bp_ready_c",  64'(in_ready),  64'd0);
    chk("bp_a_hold2",  64'(imm),       64'd1);
    chk("bp_valid_st", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step();
    chk("bp_b_imm",   64'(imm),      64'd2);
    chk("bp_ready_b", 64'(in_ready), 64'd1);
    step();
    drive(1'b0, 3'd0, 25'h0);
    chk("bp_c_imm",   64'(imm),       64'd3);
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    step();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Flush with two entries buffered and a third offered on the same cycle.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 25'h0002000);
    step();
    drive(1'b1, 3'd0, 25'h0004000);
    step();
    drive(1'b1, 3'd0, 25'h000E000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 25'h0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    chk("fl_empty1", 64'(out_valid), 64'd0);
    step();
    chk("fl_empty2", 64'(out_valid), 64'd0);

    // Flush takes priority over an accept while in_ready is high.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 25'h0002000);
    step();
    drive(1'b1, 3'd0, 25'h000E000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 25'h0);
    chk("fl2_valid", 64'(out_valid), 64'd0);
    chk("fl2_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    chk("fl2_empty", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges while the buffer is full.
    out_ready = 1'b0;
    drive(1'b1, 3'd0, 25'h0002000);
    step();
    drive(1'b1, 3'd0, 25'h0004000);
    step();
    drive(1'b0, 3'd0, 25'h0);
    chk("ar_full", 64'(in_ready), 64'd0);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ready", 64'(in_ready),  64'd1);
    chk("ar_imm",   64'(imm),       64'd0);
    #1;
    reset = 1'b0;
    step();
    chk("ar_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    drive(1'b1, 3'd2, 25'h1FC001D);
    exp_q.push_back(XLEN'(64'hFFFF_FFFF_FFFF_FFFC));
    step();
    drive(1'b0, 3'd0, 25'h0);
    chk("ar_post_valid", 64'(out_valid), 64'd1);
    chk("ar_post_imm",   64'(imm),       64'(XLEN'(64'hFFFF_FFFF_FFFF_FFFC)));
    step();
    chk("ar_post_drain", 64'(out_valid), 64'd0);

    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
IMM_EXTEND_STAGE -- requirements
Module: imm_extend_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, output immediate width; legal values are 32 and 64.
REQ-002 SHALL have parameter SRCW, default 3, width of the format select.
REQ-003 SHALL have port clk  input  1  the single clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-006 SHALL have port in_valid  input  1  upstream entry present.
REQ-007 SHALL have port in_ready  output  1  stage can accept an entry this cycle.
REQ-008 SHALL have port imm_src  input  SRCW  immediate format select.
REQ-009 SHALL have port inp  input  25  instruction bits [31:7].
REQ-010 SHALL have port out_valid  output  1  entry present at the output.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the entry.
REQ-012 SHALL have port imm  output  XLEN  sign-extended immediate.
REQ-013 SHALL have port imm_err  output  1  the entry used an unsupported imm_src.

Function
REQ-014 SHALL decode imm_src as: 0 I-type {inp[24:13]}; 1 S-type {inp[24:18],inp[4:0]}; 2 B-type {inp[24],inp[0],inp[23:18],inp[4:1],0}; 3 J-type {inp[24],inp[12:5],inp[13],inp[23:14],0}.
REQ-015 SHALL sign-extend every format to XLEN using inp[24].
REQ-016 SHALL treat any other imm_src value as unsupported: imm=0 and imm_err=1 for that entry.
REQ-017 SHALL register the decoded result, giving 1-cycle latency from accepted input to out_valid.
REQ-018 SHALL accept an entry on a cycle where in_valid and in_ready are both 1; SHALL transfer an entry out on a cycle where out_valid and out_ready are both 1.
REQ-019 SHALL contain a 2-entry skid buffer (main and skid); in_ready SHALL be a registered signal equal to NOT skid_valid.
REQ-020 SHALL park an accepted entry in skid when main is valid and out_ready=0; SHALL move skid to main when main drains.
REQ-021 SHALL, on a simultaneous accept and output transfer, replace main with the new entry without asserting skid_valid.
REQ-022 SHALL hold imm and imm_err stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve entry order; no entry is lost or duplicated.
REQ-024 SHALL, on flush=1, clear main_valid and skid_valid at the clock edge; an entry offered in the same cycle SHALL be dropped; flush takes priority over accept.

Reset
REQ-025 SHALL, on reset, immediately set out_valid=0, imm=0, imm_err=0, skid_valid=0, and in_ready=1.
REQ-026 SHALL discard all entries on reset asserted mid-transfer; the first cycle after deassertion SHALL behave as an empty stage.

Configuration
REQ-027 SHALL, with macro IMM_EXTEND_UTYPE_EN defined, decode imm_src=4 as U-type {inp[24:5],12'b0}, sign-extended to XLEN, with imm_err=0.
REQ-028 SHALL, with IMM_EXTEND_UTYPE_EN undefined, treat imm_src=4 as unsupported per REQ-016.

Structure
REQ-029 SHALL take the imm_src encodings (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U) and the XLEN default from the shared constants package.
REQ-030 SHALL implement the decode as the combinational sub-module imm_decode; the top holds only the skid buffer and handshake.

Verification
REQ-031 SHALL cover I-type: imm_src=0, inp=0x1FFE001 (addi -1) -> next cycle out_valid=1, imm=0xFFFFFFFF; with XLEN=64, imm=0xFFFFFFFFFFFFFFFF.
REQ-032 SHALL cover B-type and J-type: imm_src=2, inp=0x1FC001D -> imm=0xFFFFFFFC; imm_src=3, inp=0x0010000 -> imm=0x00000008.
REQ-033 SHALL cover backpressure: out_ready=0 with 3 back-to-back valid inputs -> two entries held, in_ready=0 on the third cycle; then out_ready=1 -> entries emerge in order, each held stable while stalled.
REQ-034 SHALL cover an unsupported source: imm_src=7 -> imm=0, imm_err=1; imm_src=4 -> imm_err=0 with IMM_EXTEND_UTYPE_EN defined (inp=0x1000000 -> imm=0x80000000 sign-extended), imm_err=1 without it.
REQ-035 SHALL cover flush with 2 entries buffered plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered entry never appears.
REQ-036 SHALL cover asynchronous reset asserted between clock edges while full -> out_valid=0 and in_ready=1 immediately, before the next clock edge.
